// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 3,
  parameter int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [OP_WIDTH-1:0]   MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  ResultValid,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W = DATA_WIDTH;

  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(7);

  localparam logic [COUNT_WIDTH-1:0] LAST =
    COUNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic                   load, step, finish;
  logic [COUNT_WIDTH-1:0] count;
  logic [W-1:0]           acc, q, opnd;
  logic                   r_div, r_rem, r_high;
  logic                   neg_res, neg_rem, special;

  // Operand decode for the acceptance cycle
  logic         is_mul, is_mulh, is_mulhsu, is_mulhu;
  logic         is_div, is_divu, is_rem, is_remu;
  logic         a_signed, b_signed, a_neg, b_neg;
  logic         any_div, is_quot, div_zero, ovf, spec_in;
  logic [W-1:0] mag_a, mag_b, spec_val;

  assign is_mul    = MulDivOp == OP_MUL;
  assign is_mulh   = MulDivOp == OP_MULH;
  assign is_mulhsu = MulDivOp == OP_MULHSU;
  assign is_mulhu  = MulDivOp == OP_MULHU;
  assign is_div    = MulDivOp == OP_DIV;
  assign is_divu   = MulDivOp == OP_DIVU;
  assign is_rem    = MulDivOp == OP_REM;
  assign is_remu   = MulDivOp == OP_REMU;

  assign a_signed = is_mul | is_mulh | is_mulhsu
                  | is_div | is_rem;
  assign b_signed = is_mul | is_mulh | is_div | is_rem;
  assign a_neg    = a_signed & SrcA[W-1];
  assign b_neg    = b_signed & SrcB[W-1];
  assign mag_a    = a_neg ? -SrcA : SrcA;
  assign mag_b    = b_neg ? -SrcB : SrcB;

  assign any_div  = is_div | is_divu | is_rem | is_remu;
  assign is_quot  = is_div | is_divu;
  assign div_zero = SrcB == '0;
  assign ovf      = (is_div | is_rem)
                  & (SrcA == MIN_NEG) & (SrcB == '1);
  assign spec_in  = any_div & (div_zero | ovf);

  // Division by zero wins over the overflow pattern
  always_comb begin
    spec_val = '0;
    if (div_zero)
      spec_val = is_quot ? '1 : SrcA;
    else
      spec_val = is_quot ? SrcA : '0;
  end

  // One iteration of either datapath
  logic [W:0]   mul_sum, div_shift;
  logic [W-1:0] div_diff;
  logic         div_ge;

  assign mul_sum   = {1'b0, acc}
                   + {1'b0, (q[0] ? opnd : '0)};
  assign div_shift = {acc, q[W-1]};
  assign div_diff  = div_shift[W-1:0] - opnd;
  assign div_ge    = div_shift >= {1'b0, opnd};

  // Sign correction and result select
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quo_s, rem_s, res_nx;

  assign prod   = {acc, q};
  assign prod_s = neg_res ? -prod : prod;
  assign quo_s  = neg_res ? -q : q;
  assign rem_s  = neg_rem ? -acc : acc;

  always_comb begin
    res_nx = prod_s[W-1:0];
    if (special)
      res_nx = q;
    else if (r_div)
      res_nx = r_rem ? rem_s : quo_s;
    else if (r_high)
      res_nx = prod_s[2*W-1:W];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and datapath strobes; Flush overrides all
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start && !Flush) begin
          load     = 1'b1;
          state_nx = spec_in ? DONE : CALC;
        end
      end
      CALC: begin
        if (Flush) begin
          state_nx = IDLE;
        end else begin
          step = 1'b1;
          if (count == LAST) state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        finish   = !Flush;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      acc     <= '0;
      q       <= '0;
      opnd    <= '0;
      r_div   <= 1'b0;
      r_rem   <= 1'b0;
      r_high  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      special <= 1'b0;
    end else if (load) begin
      count   <= '0;
      acc     <= '0;
      r_div   <= any_div;
      r_rem   <= is_rem | is_remu;
      r_high  <= !is_mul;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      special <= spec_in;
      opnd    <= any_div ? mag_b : mag_a;
      if (spec_in)      q <= spec_val;
      else if (any_div) q <= mag_a;
      else              q <= mag_b;
    end else if (step) begin
      count <= count + 1'b1;
      if (r_div) begin
        acc <= div_ge ? div_diff : div_shift[W-1:0];
        q   <= {q[W-2:0], div_ge};
      end else begin
        acc <= mul_sum[W:1];
        q   <= {mul_sum[0], q[W-1:1]};
      end
    end
  end

  // Result register and one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ResultValid <= 1'b0;
      Result      <= '0;
    end else begin
      ResultValid <= finish;
      if (finish) Result <= res_nx;
    end
  end

  assign Busy = state != IDLE;

endmodule
